// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: instruction fetch front end for the multi-cycle Tinker core.
// Issues 4-aligned word reads, tags returned words with their PC, buffers them in
// a small in-order prefetch queue and hands them to decode over valid/ready.
// A credit check (queued + live in-flight < DEPTH) keeps the queue from overflowing;
// redirects flush the queue and discard every response still in flight.

// Invariant checker for the fetch unit, kept apart from the datapath.
module tinker_fetch_unit_chk (
  input logic       clk,
  input logic       reset,
  input logic       push,
  input logic       full,
  input logic       req_valid,
  input logic [1:0] req_addr_lo
);
  // The credit rule must prevent a push onto a full queue.
  assert property (@(posedge clk) disable iff (reset) !(push && full));
  // Requested addresses are always word aligned.
  assert property (@(posedge clk) disable iff (reset) !(req_valid && (req_addr_lo != 2'b00)));
endmodule

module tinker_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;
  localparam int ONE_I     = 1;
  localparam int MAX_OUT_I = 2 * DEPTH - 1;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = ONE_I[CW-1:0];
  localparam logic [CW-1:0] DEPTH_C   = DEPTH[CW-1:0];
  localparam logic [CW-1:0] MAX_OUT_C = MAX_OUT_I[CW-1:0];
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = ONE_I[PW-1:0];

  logic [63:0]   fetch_pc_r;
  logic [63:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic          halted_r;
  logic [63:0]   pc_q_r   [DEPTH];
  logic [31:0]   word_q_r [DEPTH];

  logic [CW-1:0] live_s;
  logic [CW:0]   occ_s;
  logic          req_valid_s;
  logic          fire_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          inst_valid_s;
  logic [31:0]   inst_data_s;
  logic [63:0]   inst_pc_s;
  logic [CW-1:0] fire_c_s;
  logic [CW-1:0] rsp_c_s;
  logic [CW-1:0] push_c_s;
  logic [CW-1:0] pop_c_s;

  // Request credit, response routing and queue-head presentation.
  always_comb begin
    live_s       = outstanding_r - drop_cnt_r;
    occ_s        = {1'b0, count_r} + {1'b0, live_s};
    req_valid_s  = !reset && !halted_r && !halt && !redirect_valid &&
                   (occ_s < {1'b0, DEPTH_C}) && (outstanding_r < MAX_OUT_C);
    fire_s       = req_valid_s && mem_req_ready;
    drop_s       = mem_rsp_valid && (drop_cnt_r != CNT_ZERO);
    push_s       = mem_rsp_valid && (drop_cnt_r == CNT_ZERO) && !redirect_valid;
    full_s       = (count_r == DEPTH_C);
    inst_valid_s = (count_r != CNT_ZERO) && !halted_r;
    pop_s        = inst_valid_s && inst_ready && !redirect_valid;
    fire_c_s     = fire_s ? CNT_ONE : CNT_ZERO;
    rsp_c_s      = mem_rsp_valid ? CNT_ONE : CNT_ZERO;
    push_c_s     = push_s ? CNT_ONE : CNT_ZERO;
    pop_c_s      = pop_s ? CNT_ONE : CNT_ZERO;
    if (count_r != CNT_ZERO) begin
      inst_data_s = word_q_r[head_r];
      inst_pc_s   = pc_q_r[head_r];
    end else begin
      inst_data_s = 32'h0;
      inst_pc_s   = 64'h0;
    end
  end

  assign mem_req_valid = req_valid_s;
  assign mem_req_addr  = fetch_pc_r;
  assign inst_valid    = inst_valid_s;
  assign inst_data     = inst_data_s;
  assign inst_pc       = inst_pc_s;
  assign halted        = halted_r;

  // In-flight request count and sticky halt flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r <= CNT_ZERO;
      halted_r      <= 1'b0;
    end else begin
      outstanding_r <= outstanding_r + fire_c_s - rsp_c_s;
      halted_r      <= halted_r | halt;
    end
  end

  // PCs, drop counter and queue pointers; a redirect overrides all of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      drop_cnt_r <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
    end else if (redirect_valid) begin
      fetch_pc_r <= {redirect_pc[63:2], 2'b00};
      rsp_pc_r   <= {redirect_pc[63:2], 2'b00};
      drop_cnt_r <= outstanding_r - rsp_c_s;
      count_r    <= CNT_ZERO;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
    end else begin
      if (fire_s) fetch_pc_r <= fetch_pc_r + 64'd4;
      if (drop_s) drop_cnt_r <= drop_cnt_r - CNT_ONE;
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + 64'd4;
        tail_r   <= tail_r + PTR_ONE;
      end
      if (pop_s) head_r <= head_r + PTR_ONE;
      count_r <= count_r + push_c_s - pop_c_s;
    end
  end

  // Queue storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_q_r[tail_r]   <= rsp_pc_r;
      word_q_r[tail_r] <= mem_rsp_data;
    end
  end

  tinker_fetch_unit_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .push        (push_s),
    .full        (full_s),
    .req_valid   (req_valid_s),
    .req_addr_lo (fetch_pc_r[1:0])
  );
endmodule
